// File: rtl/hub75_scan_ctrl.sv
// HUB75 LED panel scan controller: shifts one row of pixels, blanks,
// latches, then displays it for a fixed on-time before the next row.
module hub75_scan_ctrl #(
  parameter int COLS      = 32,
  parameter int ADDR_W    = 3,
  parameter int CLK_DIV   = 6,
  parameter int BLANK_CYC = 4,
  parameter int ON_CYC    = 256
) (
  input  logic                     Clkin,
  input  logic                     Rstn,
  input  logic                     en,
  input  logic [5:0]               pix_rgb,
  output logic [$clog2(COLS)-1:0]  pix_col,
  output logic [ADDR_W-1:0]        pix_row,
  output logic                     R1,
  output logic                     G1,
  output logic                     B1,
  output logic                     R2,
  output logic                     G2,
  output logic                     B2,
  output logic                     PClk,
  output logic                     Lat,
  output logic                     OEn,
  output logic [ADDR_W-1:0]        A,
  output logic                     frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(2 * CLK_DIV);
  localparam int PW = $clog2(BLANK_CYC + ON_CYC + 2);

  localparam logic [SW-1:0] SC_LAST = SW'(2 * CLK_DIV - 1);
  localparam logic [SW-1:0] SC_HI   = SW'(CLK_DIV);
  localparam logic [SW-1:0] SC_CAP  = SW'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [PW-1:0] BLK_LAST = PW'(BLANK_CYC - 1);
  localparam logic [PW-1:0] LAT_LAST = PW'(1);
  localparam logic [PW-1:0] ON_LAST  = PW'(ON_CYC - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SHIFT   = 3'd1;
  localparam logic [2:0] BLANK   = 3'd2;
  localparam logic [2:0] LATCH   = 3'd3;
  localparam logic [2:0] DISPLAY = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [SW-1:0]     sc_q, sc_d;
  logic [CW-1:0]     col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [PW-1:0]     pc_q, pc_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [5:0]        rgb_q, rgb_d;
  logic              pclk_q, pclk_d;
  logic              lat_q, lat_d;
  logic              oen_q, oen_d;
  logic              fd_q, fd_d;

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    col_d   = col_q;
    row_d   = row_q;
    pc_d    = pc_q;
    a_d     = a_q;
    rgb_d   = rgb_q;
    fd_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SHIFT;
          sc_d    = '0;
          col_d   = '0;
        end
      end
      SHIFT: begin
        if (sc_q == SC_LAST) begin
          sc_d = '0;
          if (col_q == COL_LAST) begin
            state_d = BLANK;
            pc_d    = '0;
            a_d     = row_q;
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          sc_d = sc_q + SW'(1);
        end
      end
      BLANK: begin
        if (pc_q == BLK_LAST) begin
          state_d = LATCH;
          pc_d    = '0;
        end else begin
          pc_d = pc_q + PW'(1);
        end
      end
      LATCH: begin
        if (pc_q == LAT_LAST) begin
          state_d = DISPLAY;
          pc_d    = '0;
        end else begin
          pc_d = pc_q + PW'(1);
        end
      end
      DISPLAY: begin
        if (pc_q == ON_LAST) begin
          pc_d    = '0;
          sc_d    = '0;
          col_d   = '0;
          row_d   = row_q + ADDR_W'(1);
          fd_d    = (row_q == '1);
          state_d = en ? SHIFT : IDLE;
        end else begin
          pc_d = pc_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Source answers one cycle after pix_col changes
    if (state_q == SHIFT && sc_q == SC_CAP) begin
      rgb_d = pix_rgb;
    end
    pclk_d = (state_d == SHIFT) && (sc_d >= SC_HI);
    lat_d  = (state_d == LATCH);
    oen_d  = (state_d != DISPLAY);
  end

  always_ff @(posedge Clkin or negedge Rstn) begin
    if (!Rstn) begin
      state_q <= IDLE;
      sc_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      pc_q    <= '0;
      a_q     <= '0;
      rgb_q   <= '0;
      pclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      oen_q   <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      rgb_q   <= rgb_d;
      pclk_q  <= pclk_d;
      lat_q   <= lat_d;
      oen_q   <= oen_d;
      fd_q    <= fd_d;
    end
  end

  assign pix_col    = col_q;
  assign pix_row    = row_q;
  assign {R1, G1, B1, R2, G2, B2} = rgb_q;
  assign PClk       = pclk_q;
  assign Lat        = lat_q;
  assign OEn        = oen_q;
  assign A          = a_q;
  assign frame_done = fd_q;

endmodule
